axis_width_downconverter: RTL



---
 rtl/axis_width_downconverter_pkg.sv | 18 +
 rtl/axis_width_downconverter.sv | 108 ++++++++++
 2 files changed

// File: rtl/axis_width_downconverter_pkg.sv
// Shared types and elaboration helpers for the AXI-stream width downconverter.
package axis_width_downconverter_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } dwc_state_e;

    function automatic int unsigned chunk_ratio(input int unsigned in_w, input int unsigned out_w);
        return in_w / out_w;
    endfunction

    // Input must split into a whole number (at least two) of output chunks.
    function automatic bit widths_ok(input int unsigned in_w, input int unsigned out_w);
        return (out_w > 0) && ((in_w % out_w) == 0) && ((in_w / out_w) >= 2);
    endfunction

endpackage

// File: rtl/axis_width_downconverter.sv
// Splits each full-width AXI-stream word into RATIO narrower chunks, with
// zero-bubble back-to-back words and tlast on the final chunk of a tlast word.
module axis_width_downconverter
    import axis_width_downconverter_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH  = 32,
    parameter int OUTPUT_DATA_WIDTH = 8,
    parameter bit MSB_FIRST         = 1'b1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [INPUT_DATA_WIDTH-1:0]  data_in,
    input  logic                         data_in_valid,
    input  logic                         data_in_tlast,
    output logic                         data_in_ready,
    output logic [OUTPUT_DATA_WIDTH-1:0] data_out,
    output logic                         data_out_valid,
    output logic                         data_out_tlast,
    input  logic                         data_out_ready,
    output logic                         busy
);

    localparam int unsigned RATIO = chunk_ratio(INPUT_DATA_WIDTH, OUTPUT_DATA_WIDTH);
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    if (!widths_ok(INPUT_DATA_WIDTH, OUTPUT_DATA_WIDTH)) begin : g_width_check
        $error("INPUT_DATA_WIDTH must be a multiple (>=2x) of OUTPUT_DATA_WIDTH");
    end

    dwc_state_e                  state_q, state_d;
    logic [INPUT_DATA_WIDTH-1:0] shift_reg_q, shift_reg_d;
    logic [CNT_W-1:0]            chunk_cnt_q, chunk_cnt_d;
    logic                        held_last_q, held_last_d;
    logic                        out_valid_q, out_valid_d;
    logic                        out_tlast_q, out_tlast_d;

    logic             last_chunk;
    logic             handshake;
    logic             load;
    logic [CNT_W-1:0] next_cnt;

    assign last_chunk = (chunk_cnt_q == LAST_CNT);
    assign handshake  = out_valid_q & data_out_ready;
    assign next_cnt   = chunk_cnt_q + 1'b1;

    // Ready reaches back through data_out_ready so a waiting word loads in the last-chunk cycle.
    always_comb begin
        data_in_ready = reset & ((state_q == IDLE) |
                                 ((state_q == SHIFT) & last_chunk & data_out_ready));
    end

    assign load = data_in_ready & data_in_valid;

    always_comb begin
        state_d     = state_q;
        shift_reg_d = shift_reg_q;
        chunk_cnt_d = chunk_cnt_q;
        held_last_d = held_last_q;
        out_valid_d = out_valid_q;
        out_tlast_d = out_tlast_q;
        if (load) begin
            shift_reg_d = data_in;
            held_last_d = data_in_tlast;
            chunk_cnt_d = '0;
            out_valid_d = 1'b1;
            out_tlast_d = 1'b0;
            state_d     = SHIFT;
        end else if (handshake) begin
            if (last_chunk) begin
                out_valid_d = 1'b0;
                out_tlast_d = 1'b0;
                state_d     = IDLE;
            end else begin
                shift_reg_d = MSB_FIRST ? (shift_reg_q << OUTPUT_DATA_WIDTH)
                                        : (shift_reg_q >> OUTPUT_DATA_WIDTH);
                chunk_cnt_d = next_cnt;
                out_tlast_d = held_last_q & (next_cnt == LAST_CNT);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            shift_reg_q <= '0;
            chunk_cnt_q <= '0;
            held_last_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_tlast_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_reg_q <= shift_reg_d;
            chunk_cnt_q <= chunk_cnt_d;
            held_last_q <= held_last_d;
            out_valid_q <= out_valid_d;
            out_tlast_q <= out_tlast_d;
        end
    end

    // The current chunk always sits at the leading end of the shift register.
    assign data_out       = MSB_FIRST ? shift_reg_q[INPUT_DATA_WIDTH-1 -: OUTPUT_DATA_WIDTH]
                                      : shift_reg_q[OUTPUT_DATA_WIDTH-1:0];
    assign data_out_valid = out_valid_q;
    assign data_out_tlast = out_tlast_q;
    assign busy           = (state_q == SHIFT);

endmodule
